// File: rtl/br_resolve_queue.sv
// -----------------------------------------------------------------------------
// br_resolve_queue
//   Multi-thread branch resolution unit. Each cycle at most one BRANCH or
//   UNCOND_BRANCH op is resolved (direction, target, mispredict) and queued in
//   the FIFO of its thread. One result per cycle is drained round-robin to the
//   CDB/ROB under a valid/ready handshake. Threads can be squashed
//   individually, and each thread keeps a saturating mispredict counter.
//
// Ports
//   clock, reset          clock; asynchronous active-low reset
//   in_valid / in_ready   issue handshake; in_ready[t] means FIFO t has space
//   in_tid .. in_dest_prn branch op fields from the issue stage
//   squash_valid/_tid     empty the FIFO of one thread
//   out_valid / out_ready result handshake towards the CDB/ROB
//   out_tid .. out_mispredict  resolved result at the head of the chosen FIFO
//   mispred_cnt           per-thread counters, thread t at [t*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module br_resolve_queue #(
  parameter int XLEN    = 64,
  parameter int DISP_W  = 21,
  parameter int THREADS = 2,
  parameter int DEPTH   = 4,
  parameter int ROB_W   = 5,
  parameter int PRN_W   = 7,
  parameter int CNT_W   = 16,
  parameter int TID_W   = (THREADS > 1) ? $clog2(THREADS) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic [THREADS-1:0]       in_ready,
  input  logic [TID_W-1:0]         in_tid,
  input  logic                     in_uncond,
  input  logic                     in_is_jump,
  input  logic [2:0]               in_cond_op,
  input  logic [DISP_W-1:0]        in_disp,
  input  logic [XLEN-1:0]          in_next_pc,
  input  logic [XLEN-1:0]          in_op1,
  input  logic [XLEN-1:0]          in_op2,
  input  logic                     in_pred_taken,
  input  logic [XLEN-1:0]          in_pred_target,
  input  logic [ROB_W-1:0]         in_rob_idx,
  input  logic [PRN_W-1:0]         in_dest_prn,
  input  logic                     squash_valid,
  input  logic [TID_W-1:0]         squash_tid,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TID_W-1:0]         out_tid,
  output logic [ROB_W-1:0]         out_rob_idx,
  output logic [PRN_W-1:0]         out_dest_prn,
  output logic [XLEN-1:0]          out_result,
  output logic [XLEN-1:0]          out_redirect_pc,
  output logic                     out_taken,
  output logic                     out_mispredict,
  output logic [THREADS*CNT_W-1:0] mispred_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    COND_LBC = 2'b00,
    COND_EQ  = 2'b01,
    COND_LT  = 2'b10,
    COND_LE  = 2'b11
  } cond_e;

  typedef struct packed {
    logic [ROB_W-1:0] rob_idx;
    logic [PRN_W-1:0] dest_prn;
    logic [XLEN-1:0]  result;
    logic [XLEN-1:0]  redirect_pc;
    logic             taken;
    logic             mispredict;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Resolve the incoming op (purely combinational on the issue inputs)
  // ---------------------------------------------------------------------------
  entry_t          res_entry;
  logic            op2_zero;
  logic            cond_raw;
  logic            res_taken;
  logic [XLEN-1:0] disp_off;
  logic [XLEN-1:0] res_target;

  // NOTE: every signal written here gets a default first so that no path
  // through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    op2_zero   = (in_op2 == '0);
    cond_raw   = 1'b0;
    res_taken  = 1'b0;
    disp_off   = '0;
    res_target = '0;
    res_entry  = '0;

    case (cond_e'(in_cond_op[1:0]))
      COND_LBC: cond_raw = ~in_op2[0];
      COND_EQ:  cond_raw = op2_zero;
      COND_LT:  cond_raw = in_op2[XLEN-1];
      COND_LE:  cond_raw = in_op2[XLEN-1] | op2_zero;
      default:  cond_raw = 1'b0;
    endcase

    res_taken = in_uncond ? 1'b1 : (cond_raw ^ in_cond_op[2]);

    // Displacement counts instruction words: sign-extend, then scale by 4.
    disp_off   = {{(XLEN-DISP_W){in_disp[DISP_W-1]}}, in_disp} << 2;
    res_target = (in_uncond && in_is_jump) ? (in_op1 & in_op2)
                                           : (in_next_pc + disp_off);

    res_entry.rob_idx     = in_rob_idx;
    res_entry.dest_prn    = in_dest_prn;
    res_entry.result      = in_uncond ? in_next_pc : '0;
    res_entry.redirect_pc = res_taken ? res_target : in_next_pc;
    res_entry.taken       = res_taken;
    res_entry.mispredict  = (res_taken != in_pred_taken) ||
                            (res_taken && (res_target != in_pred_target));
  end

  // ---------------------------------------------------------------------------
  // Per-thread FIFO state
  // ---------------------------------------------------------------------------
  entry_t           mem_q   [THREADS][DEPTH];
  logic [PTR_W-1:0] wr_ptr_q[THREADS], wr_ptr_d[THREADS];
  logic [PTR_W-1:0] rd_ptr_q[THREADS], rd_ptr_d[THREADS];
  logic [PTR_W:0]   count_q [THREADS], count_d [THREADS];
  logic [CNT_W-1:0] cnt_q   [THREADS], cnt_d   [THREADS];
  logic [TID_W-1:0] rr_q, rr_d;

  logic [THREADS-1:0] push;
  logic [THREADS-1:0] pop;
  logic               cand_found;
  logic [TID_W-1:0]   cand_tid;
  entry_t             head;

  // in_ready depends only on registered occupancy, so a pop in the same cycle
  // never opens a slot (no out_ready -> in_ready combinational path).
  always_comb begin
    in_ready = '0;
    for (int t = 0; t < THREADS; t++) begin
      in_ready[t] = (count_q[t] != FULL_CNT);
    end
  end

  // Round-robin pick: first non-empty FIFO starting at rr_q; a thread being
  // squashed this cycle is never offered.
  always_comb begin
    cand_found = 1'b0;
    cand_tid   = '0;
    for (int i = 0; i < THREADS; i++) begin
      int t;
      t = int'(rr_q) + i;
      if (t >= THREADS) t = t - THREADS;
      if (!cand_found && (count_q[t] != '0) &&
          !(squash_valid && (squash_tid == TID_W'(t)))) begin
        cand_found = 1'b1;
        cand_tid   = TID_W'(t);
      end
    end
  end

  always_comb begin
    head            = mem_q[cand_tid][rd_ptr_q[cand_tid]];
    out_valid       = cand_found;
    out_tid         = cand_found ? cand_tid         : '0;
    out_rob_idx     = cand_found ? head.rob_idx     : '0;
    out_dest_prn    = cand_found ? head.dest_prn    : '0;
    out_result      = cand_found ? head.result      : '0;
    out_redirect_pc = cand_found ? head.redirect_pc : '0;
    out_taken       = cand_found ? head.taken       : 1'b0;
    out_mispredict  = cand_found ? head.mispredict  : 1'b0;
  end

  always_comb begin
    push = '0;
    pop  = '0;
    rr_d = rr_q;
    for (int t = 0; t < THREADS; t++) begin
      push[t] = in_valid && (in_tid == TID_W'(t)) && in_ready[t] &&
                !(squash_valid && (squash_tid == TID_W'(t)));
      pop[t]  = cand_found && out_ready && (cand_tid == TID_W'(t));

      wr_ptr_d[t] = wr_ptr_q[t];
      rd_ptr_d[t] = rd_ptr_q[t];
      count_d[t]  = count_q[t];
      cnt_d[t]    = cnt_q[t];

      if (squash_valid && (squash_tid == TID_W'(t))) begin
        wr_ptr_d[t] = '0;
        rd_ptr_d[t] = '0;
        count_d[t]  = '0;
      end else begin
        // Pointers wrap naturally because DEPTH is a power of two.
        if (push[t]) wr_ptr_d[t] = wr_ptr_q[t] + PTR_W'(1);
        if (pop[t])  rd_ptr_d[t] = rd_ptr_q[t] + PTR_W'(1);
        if (push[t] && !pop[t]) count_d[t] = count_q[t] + (PTR_W+1)'(1);
        if (!push[t] && pop[t]) count_d[t] = count_q[t] - (PTR_W+1)'(1);
      end

      if (pop[t] && head.mispredict && (cnt_q[t] != '1)) begin
        cnt_d[t] = cnt_q[t] + CNT_W'(1);
      end
    end

    if (cand_found && out_ready) begin
      rr_d = (cand_tid == TID_W'(THREADS-1)) ? '0 : cand_tid + TID_W'(1);
    end
  end

  always_comb begin
    mispred_cnt = '0;
    for (int t = 0; t < THREADS; t++) begin
      mispred_cnt[t*CNT_W +: CNT_W] = cnt_q[t];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its next value from the same pre-edge state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_q <= '0;
      for (int t = 0; t < THREADS; t++) begin
        wr_ptr_q[t] <= '0;
        rd_ptr_q[t] <= '0;
        count_q[t]  <= '0;
        cnt_q[t]    <= '0;
      end
    end else begin
      rr_q <= rr_d;
      for (int t = 0; t < THREADS; t++) begin
        wr_ptr_q[t] <= wr_ptr_d[t];
        rd_ptr_q[t] <= rd_ptr_d[t];
        count_q[t]  <= count_d[t];
        cnt_q[t]    <= cnt_d[t];
      end
    end
  end

  // NOTE: the storage array has no reset; occupancy counts gate every read,
  // so stale contents are never observable and the array maps onto plain RAM.
  always_ff @(posedge clock) begin
    for (int t = 0; t < THREADS; t++) begin
      if (push[t]) mem_q[t][wr_ptr_q[t]] <= res_entry;
    end
  end

endmodule
